// File: rtl/stopwatch_bcd_pkg.sv
// stopwatch_bcd: shared digit limits, BCD field layout and time word type.
// The field positions are also consumed by the seven-segment decoder stage.
package stopwatch_pkg;

  localparam int CS_MAX        = 9;
  localparam int SEC_TENS_MAX  = 5;
  localparam int MIN_TENS_MAX  = 5;
  localparam int HOUR_TENS_MAX = 2;
  localparam int HOUR_WRAP     = 23;

  localparam int CSU_LSB = 0;
  localparam int CST_LSB = 4;
  localparam int SU_LSB  = 8;
  localparam int ST_LSB  = 12;
  localparam int MU_LSB  = 16;
  localparam int MT_LSB  = 20;
  localparam int HU_LSB  = 24;
  localparam int HT_LSB  = 28;

  typedef logic [31:0] time_bcd_t;

endpackage

// File: rtl/stopwatch_bcd_if.sv
// stopwatch_bcd: control pulses in, packed BCD time and status out.
// master drives the pulses, slave is the stopwatch core.
interface stopwatch_bcd_if;
  import stopwatch_pkg::*;

  logic      start_stop;
  logic      clear;
  logic      lap;
  time_bcd_t time_bcd;
  logic      running;
  logic      lap_active;

  modport master (
    output start_stop, clear, lap,
    input  time_bcd, running, lap_active
  );

  modport slave (
    input  start_stop, clear, lap,
    output time_bcd, running, lap_active
  );
endinterface

// File: rtl/stopwatch_bcd_digit_counter.sv
// stopwatch_bcd: one BCD digit of the time chain.
// Wraps to 0 at its active limit; carry enables the next digit.
module bcd_digit_counter #(
  parameter logic [3:0] MAX     = 4'd9,
  parameter logic [3:0] OVR_MAX = MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  input  logic       max_override,
  output logic [3:0] digit,
  output logic       carry
);

  logic [3:0] q;
  logic [3:0] lim;

  assign lim   = max_override ? OVR_MAX : MAX;
  assign carry = inc && (q == lim);
  assign digit = q;

  // advance on inc, wrap at the active limit; clr wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (inc)
      q <= (q == lim) ? 4'd0 : q + 4'd1;
  end

  // a digit above its limit means the chain is broken
  always_comb assert (q <= MAX);

endmodule

// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: HH:MM:SS.CC stopwatch core with lap freeze.
// Prescaler makes the centisecond tick; output word is registered.
module stopwatch_bcd #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_DIV = CLK_HZ / 100
) (
  input logic            clk,
  input logic            rst,
  stopwatch_bcd_if.slave sw
);
  import stopwatch_pkg::*;

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre;
  logic          tick;
  logic          running_q;
  logic          lap_q;
  time_bcd_t     live;
  time_bcd_t     time_q;
  logic          hour_top;
  logic          c_cs0, c_cs1, c_s0, c_s1;
  logic          c_m0, c_m1, c_h0;
  logic          day_wrap_unused;

  assign tick     = running_q && (pre == PRE_LAST);
  assign hour_top = live[HT_LSB +: 4] == 4'(HOUR_TENS_MAX);

  bcd_digit_counter #(.MAX(4'(CS_MAX))) u_csu (
    .clk(clk), .rst(rst), .inc(tick), .clr(sw.clear),
    .max_override(1'b0),
    .digit(live[CSU_LSB +: 4]), .carry(c_cs0)
  );

  bcd_digit_counter #(.MAX(4'(CS_MAX))) u_cst (
    .clk(clk), .rst(rst), .inc(c_cs0), .clr(sw.clear),
    .max_override(1'b0),
    .digit(live[CST_LSB +: 4]), .carry(c_cs1)
  );

  bcd_digit_counter #(.MAX(4'(CS_MAX))) u_su (
    .clk(clk), .rst(rst), .inc(c_cs1), .clr(sw.clear),
    .max_override(1'b0),
    .digit(live[SU_LSB +: 4]), .carry(c_s0)
  );

  bcd_digit_counter #(.MAX(4'(SEC_TENS_MAX))) u_st (
    .clk(clk), .rst(rst), .inc(c_s0), .clr(sw.clear),
    .max_override(1'b0),
    .digit(live[ST_LSB +: 4]), .carry(c_s1)
  );

  bcd_digit_counter #(.MAX(4'(CS_MAX))) u_mu (
    .clk(clk), .rst(rst), .inc(c_s1), .clr(sw.clear),
    .max_override(1'b0),
    .digit(live[MU_LSB +: 4]), .carry(c_m0)
  );

  bcd_digit_counter #(.MAX(4'(MIN_TENS_MAX))) u_mt (
    .clk(clk), .rst(rst), .inc(c_m0), .clr(sw.clear),
    .max_override(1'b0),
    .digit(live[MT_LSB +: 4]), .carry(c_m1)
  );

  bcd_digit_counter #(
    .MAX(4'(CS_MAX)),
    .OVR_MAX(4'(HOUR_WRAP % 10))
  ) u_hu (
    .clk(clk), .rst(rst), .inc(c_m1), .clr(sw.clear),
    .max_override(hour_top),
    .digit(live[HU_LSB +: 4]), .carry(c_h0)
  );

  bcd_digit_counter #(.MAX(4'(HOUR_TENS_MAX))) u_ht (
    .clk(clk), .rst(rst), .inc(c_h0), .clr(sw.clear),
    .max_override(1'b0),
    .digit(live[HT_LSB +: 4]), .carry(day_wrap_unused)
  );

  // run/lap toggles and prescaler; clear overrides both pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running_q <= 1'b0;
      lap_q     <= 1'b0;
      pre       <= '0;
    end else if (sw.clear) begin
      running_q <= 1'b0;
      lap_q     <= 1'b0;
      pre       <= '0;
    end else begin
      if (sw.start_stop)
        running_q <= ~running_q;
      if (sw.lap)
        lap_q <= ~lap_q;
      if (tick)
        pre <= '0;
      else if (running_q)
        pre <= pre + PW'(1);
    end
  end

  // output follows live digits except while a lap snapshot is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      time_q <= '0;
    else if (sw.clear)
      time_q <= '0;
    else if (!(lap_q && !sw.lap))
      time_q <= live;
  end

  assign sw.time_bcd   = time_q;
  assign sw.running    = running_q;
  assign sw.lap_active = lap_q;

endmodule

// File: doc/stopwatch_bcd.md
# stopwatch_bcd

Stopwatch/clock core that counts elapsed time as packed BCD HH:MM:SS.CC and feeds the 8-digit seven-segment decoder stage directly downstream. A prescaler derives a 100 Hz centisecond tick from the system clock. A cascade of BCD digit counters produces a 32-bit time word in the exact nibble layout the decoder consumes. Start/stop, clear and lap-freeze controls come from debounced, single-cycle pulses.

## Interface
- CLK_HZ, 50_000_000, system clock frequency in Hz
- TICK_DIV, CLK_HZ/100, clocks per centisecond tick; must be ≥2; benches override it with a small value
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset: asynchronous, active-high
- start_stop  in  1  one-cycle pulse; toggles running
- clear  in  1  one-cycle pulse; zeroes time and stops
- lap  in  1  one-cycle pulse; toggles display freeze
- time_bcd  out  32  [31:28] hour tens, [27:24] hour units, [23:20] min tens, [19:16] min units, [15:12] sec tens, [11:8] sec units, [7:4] cs tens, [3:0] cs units
- running  out  1  counting enabled
- lap_active  out  1  time_bcd frozen at lap snapshot

## Operation
- Reset values: all digits 0, prescaler 0, running=0, lap_active=0, time_bcd=32'h0000_0000.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while running.
  - tick = running && prescaler==TICK_DIV-1; prescaler wraps to 0 on tick.
  - When stopped, the prescaler holds its value; resume continues the partial period.
- Digit chain on tick:
  - cs units 0-9, cs tens 0-9, sec units 0-9, sec tens 0-5, min units 0-9, min tens 0-5.
  - Hours 00-23: hour units wraps at 9, or at 3 when hour tens is 2; hour tens 0-2.
  - Each digit increments when all lower digits are at their maximum. 23:59:59.99 + tick -> 00:00:00.00 (silent wrap, no flag).
- Digits never hold a non-BCD value (A-F). An out-of-range value is a design error and is asserted against in simulation.
- start_stop: running <= ~running.
- lap:
  - When lap_active=0: snapshot the current live digits into the output register and set lap_active=1. Live counting continues.
  - When lap_active=1: clear lap_active; time_bcd follows live digits again.
- clear: live digits 0, prescaler 0, running 0, lap_active 0.
- Simultaneous events:
  - clear overrides start_stop and lap in the same cycle.
  - start_stop and lap together both take effect.
  - A tick coinciding with start_stop (stop) is still counted.
  - A lap in the same cycle as a tick snapshots the pre-tick value.
- Control inputs are synchronous, debounced, single-cycle pulses from upstream. A held-high input toggles every cycle; this is not filtered.

## Timing
- time_bcd is registered.
  - Unfrozen: it shows the live value from the cycle after each tick edge. Digit update occurs on the tick edge; output follows one cycle later (latency 1).
  - On lap, the frozen value appears the cycle after the lap pulse.
- running and lap_active change on the edge after the pulse.
- The first tick after start occurs TICK_DIV cycles after running rises (from prescaler 0).
- Reset mid-count returns all outputs to reset values immediately (asynchronous); the first edge after deassertion takes no action.

## Structure
- Shared package stopwatch_pkg holds:
  - digit limit constants (CS_MAX=9, SEC_TENS_MAX=5, MIN_TENS_MAX=5, HOUR_TENS_MAX=2, HOUR_WRAP=23);
  - field bit-position constants for the 32-bit BCD word, shared with the decoder stage;
  - a typedef for the packed time word.
- One sub-module: bcd_digit_counter. Parameterised max value; inputs inc, clr, max_override (hour units); outputs 4-bit digit and carry (inc && digit==max). Instantiated 8 times.

## Test plan
- Reset, then start_stop pulse with TICK_DIV=4 -> running=1; first time_bcd change to 32'h0000_0001 exactly 5 cycles after running rises.
- Preload to 32'h0959_5999, then one tick -> 32'h1000_0000.
- Preload to 32'h2359_5999, then one tick -> 32'h0000_0000, with no non-BCD nibble ever seen.
- While running at 32'h0000_0042, pulse lap -> time_bcd holds 32'h0000_0042 and lap_active=1 for 10 ticks. Second lap -> output jumps to the live value 32'h0000_0052.
- clear and start_stop in the same cycle while running -> running=0 and time 32'h0; a later start_stop resumes from 0.
- Assert rst mid-count for a sub-cycle pulse -> all outputs 0 immediately, stopwatch stays stopped after release.
